// File: rtl/cond_exec_unit_if.sv
// Execute-stage conditional-execution bus: unconditioned controls and IT
// fields in, conditioned controls and NZCV/IT status out.
interface cond_exec_unit_if #(
  parameter int IT_DEPTH = 4
);
  localparam int CNT_W = $clog2(IT_DEPTH + 1);

  logic                ValidE;
  logic                StallE;
  logic                FlushE;
  logic                PCSrcEIn;
  logic                RegWriteEIn;
  logic                MemWriteEIn;
  logic                BranchEIn;
  logic                NoWrite;
  logic [1:0]          FlagWriteE;
  logic [3:0]          CondE;
  logic [3:0]          ALUFlags;
  logic                ITStartE;
  logic [3:0]          ITCondE;
  logic [CNT_W-1:0]    ITLenE;
  logic [IT_DEPTH-1:0] ITMaskE;

  logic                PCSrcE;
  logic                RegWriteE;
  logic                MemWriteE;
  logic                BranchE;
  logic [3:0]          FlagsOut;
  logic                CondExE;
  logic                ITActive;
  logic [CNT_W-1:0]    ITRemain;
  logic                CondUndef;
  logic                ITError;

  modport master (
    output ValidE, StallE, FlushE, PCSrcEIn, RegWriteEIn, MemWriteEIn, BranchEIn,
           NoWrite, FlagWriteE, CondE, ALUFlags, ITStartE, ITCondE, ITLenE, ITMaskE,
    input  PCSrcE, RegWriteE, MemWriteE, BranchE, FlagsOut, CondExE, ITActive,
           ITRemain, CondUndef, ITError
  );

  modport slave (
    input  ValidE, StallE, FlushE, PCSrcEIn, RegWriteEIn, MemWriteEIn, BranchEIn,
           NoWrite, FlagWriteE, CondE, ALUFlags, ITStartE, ITCondE, ITLenE, ITMaskE,
    output PCSrcE, RegWriteE, MemWriteE, BranchE, FlagsOut, CondExE, ITActive,
           ITRemain, CondUndef, ITError
  );
endinterface

// File: rtl/cond_exec_unit.sv
// Execute-stage condition check with NZCV register, stall/flush/bubble handling
// and an IT-block sequencer predicating up to IT_DEPTH following instructions.
module cond_exec_unit #(
  parameter  int IT_DEPTH = 4,
  localparam int CNT_W    = $clog2(IT_DEPTH + 1),
  localparam int IDX_W    = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1
) (
  input logic              CLK,
  input logic              RESET,
  cond_exec_unit_if.slave  bus
);

  typedef enum logic {IDLE, IT_ACT} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    it_remain_q;
  logic [IDX_W-1:0]    it_idx_q;
  logic [3:0]          it_cond_q;
  logic [IT_DEPTH-1:0] it_mask_q;
  logic                it_error_q;
  logic [3:0]          flags_q, flags_d;

  logic [3:0] eff_cond;
  logic       cond_ok;
  logic       gate;
  logic       adv;
  logic       len_ok;
  logic       start_ok;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = ~cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = cf & ~z;
      4'h9:    cond_pass = ~cf | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Inside an IT block each slot uses the base condition, with bit 0 flipped when its mask bit is 0.
  assign eff_cond = (state_q == IT_ACT) ? {it_cond_q[3:1], it_cond_q[0] ^ ~it_mask_q[it_idx_q]}
                                        : bus.CondE;
  assign cond_ok  = cond_pass(eff_cond, flags_q);
  assign gate     = bus.ValidE & ~bus.FlushE & cond_ok;
  assign adv      = bus.ValidE & ~bus.StallE & ~bus.FlushE;
  assign len_ok   = (bus.ITLenE != '0) && (bus.ITLenE <= CNT_W'(IT_DEPTH));
  assign start_ok = (state_q == IDLE) & adv & bus.ITStartE & len_ok;

  assign bus.CondExE   = cond_ok;
  assign bus.CondUndef = (eff_cond == 4'hF);
  assign bus.RegWriteE = bus.RegWriteEIn & gate & ~bus.NoWrite;
  assign bus.MemWriteE = bus.MemWriteEIn & gate;
  assign bus.PCSrcE    = bus.PCSrcEIn & gate;
  assign bus.BranchE   = bus.BranchEIn & gate;
  assign bus.FlagsOut  = flags_q;
  assign bus.ITActive  = (state_q == IT_ACT);
  assign bus.ITRemain  = it_remain_q;
  assign bus.ITError   = it_error_q;

  always_comb begin
    flags_d = flags_q;
    if (gate && !bus.StallE) begin
      if (bus.FlagWriteE[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) flags_q <= 4'h0;
    else       flags_q <= flags_d;
  end

  always_ff @(posedge CLK) begin
    if (start_ok) begin
      it_cond_q <= bus.ITCondE;
      it_mask_q <= bus.ITMaskE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      it_remain_q <= '0;
      it_idx_q    <= '0;
      it_error_q  <= 1'b0;
    end else if (bus.FlushE) begin
      state_q     <= IDLE;
      it_remain_q <= '0;
      it_idx_q    <= '0;
      it_error_q  <= 1'b0;
    end else if (bus.StallE) begin
      it_error_q  <= 1'b0;
    end else begin
      it_error_q <= 1'b0;
      if (bus.ValidE) begin
        case (state_q)
          IDLE: begin
            if (bus.ITStartE) begin
              if (len_ok) begin
                state_q     <= IT_ACT;
                it_remain_q <= bus.ITLenE;
                it_idx_q    <= '0;
              end else begin
                it_error_q  <= 1'b1;
              end
            end
          end
          IT_ACT: begin
            // A nested IT is executed as an ordinary predicated slot.
            if (bus.ITStartE) it_error_q <= 1'b1;
            it_remain_q <= it_remain_q - 1'b1;
            if (it_remain_q == CNT_W'(1)) begin
              state_q  <= IDLE;
              it_idx_q <= '0;
            end else begin
              it_idx_q <= it_idx_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: directed scenarios plus randomized traffic against
// a queue-based model of the IT block and NZCV register.
module tb_cond_exec_unit;
  localparam int IT_DEPTH = 4;
  localparam int CNT_W    = $clog2(IT_DEPTH + 1);

  logic CLK;
  logic RESET;
  int   n_chk = 0;
  int   n_err = 0;

  cond_exec_unit_if #(.IT_DEPTH(IT_DEPTH)) bus ();
  cond_exec_unit #(.IT_DEPTH(IT_DEPTH)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference state: pending slot conditions of the open IT block, oldest first.
  bit [3:0] m_flags;
  bit [3:0] m_slots[$];
  bit       m_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit arm_cond(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic bit [3:0] m_eff();
    return (m_slots.size() != 0) ? m_slots[0] : bus.CondE;
  endfunction

  task automatic settle();
    bit [3:0] e;
    bit       pass, g;
    #4;
    e    = m_eff();
    pass = arm_cond(e, m_flags);
    g    = bus.ValidE && !bus.FlushE && pass;
    chk("CondExE",   bus.CondExE,   pass);
    chk("CondUndef", bus.CondUndef, e == 4'hF);
    chk("RegWriteE", bus.RegWriteE, bus.RegWriteEIn && g && !bus.NoWrite);
    chk("MemWriteE", bus.MemWriteE, bus.MemWriteEIn && g);
    chk("PCSrcE",    bus.PCSrcE,    bus.PCSrcEIn && g);
    chk("BranchE",   bus.BranchE,   bus.BranchEIn && g);
    chk("FlagsOut",  bus.FlagsOut,  m_flags);
    chk("ITActive",  bus.ITActive,  m_slots.size() != 0);
    chk("ITRemain",  bus.ITRemain,  m_slots.size());
    chk("ITError",   bus.ITError,   m_err);
  endtask

  task automatic model_step();
    bit g;
    g = bus.ValidE && !bus.FlushE && arm_cond(m_eff(), m_flags);
    if (RESET) begin
      m_flags = 4'h0; m_slots.delete(); m_err = 1'b0;
    end else if (bus.FlushE) begin
      m_slots.delete(); m_err = 1'b0;
    end else if (bus.StallE) begin
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (g && bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (g && bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      if (bus.ValidE) begin
        if (m_slots.size() != 0) begin
          if (bus.ITStartE) m_err = 1'b1;
          void'(m_slots.pop_front());
        end else if (bus.ITStartE) begin
          if (bus.ITLenE >= 1 && bus.ITLenE <= IT_DEPTH) begin
            for (int i = 0; i < int'(bus.ITLenE); i++)
              m_slots.push_back({bus.ITCondE[3:1], bus.ITCondE[0] ^ !bus.ITMaskE[i]});
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    RESET = 1'b0;
    bus.ValidE = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    bus.PCSrcEIn = 1'b0; bus.RegWriteEIn = 1'b0; bus.MemWriteEIn = 1'b0; bus.BranchEIn = 1'b0;
    bus.NoWrite = 1'b0; bus.FlagWriteE = 2'b00; bus.CondE = 4'hE; bus.ALUFlags = 4'h0;
    bus.ITStartE = 1'b0; bus.ITCondE = 4'h0; bus.ITLenE = '0; bus.ITMaskE = '0;
  endtask

  task automatic instr(input bit [3:0] cond);
    idle();
    bus.ValidE = 1'b1; bus.CondE = cond;
    bus.RegWriteEIn = 1'b1; bus.MemWriteEIn = 1'b1; bus.PCSrcEIn = 1'b1; bus.BranchEIn = 1'b1;
  endtask

  task automatic set_flags(input bit [3:0] f);
    instr(4'hE); bus.FlagWriteE = 2'b11; bus.ALUFlags = f;
    settle(); tick();
  endtask

  task automatic it_start(input bit [3:0] c, input int len, input bit [IT_DEPTH-1:0] mask);
    instr(4'hE); bus.ITStartE = 1'b1; bus.ITCondE = c;
    bus.ITLenE = CNT_W'(len); bus.ITMaskE = mask;
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    tick(); tick();
    settle();
    chk("rst_flags",  bus.FlagsOut, 4'h0);
    chk("rst_active", bus.ITActive, 1'b0);
    chk("rst_remain", bus.ITRemain, 0);
    chk("rst_err",    bus.ITError,  1'b0);
    RESET = 1'b0;
    instr(4'h0); settle(); chk("rst_eq_fail", bus.CondExE, 1'b0);
    instr(4'h1); settle(); chk("rst_ne_pass", bus.CondExE, 1'b1);
    tick();

    // Basic condition evaluation with Z set
    set_flags(4'b0100);
    instr(4'h0); settle(); chk("eq_rw", bus.RegWriteE, 1'b1);
    instr(4'h1); settle(); chk("ne_rw", bus.RegWriteE, 1'b0);
    instr(4'hF); settle(); chk("nv_ex", bus.CondExE, 1'b0); chk("nv_undef", bus.CondUndef, 1'b1);
    idle(); tick();

    // CMP then partial flag write
    instr(4'hE); bus.NoWrite = 1'b1; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1001;
    settle(); chk("cmp_rw", bus.RegWriteE, 1'b0); tick();
    instr(4'hE); bus.FlagWriteE = 2'b10; bus.ALUFlags = 4'b0110;
    settle(); chk("cmp_flags", bus.FlagsOut, 4'b1001); tick();
    idle(); settle(); chk("nz_flags", bus.FlagsOut, 4'b0101);

    // IT EQ, len 3, mask 101
    set_flags(4'b0100);
    it_start(4'h0, 3, 4'b0101); settle(); tick();
    instr(4'hE); settle(); chk("it_s0_ex", bus.CondExE, 1'b1); chk("it_s0_rem", bus.ITRemain, 3); tick();
    instr(4'hE); settle(); chk("it_s1_ex", bus.CondExE, 1'b0); chk("it_s1_rem", bus.ITRemain, 2); tick();
    instr(4'hE); settle(); chk("it_s2_ex", bus.CondExE, 1'b1); chk("it_s2_rem", bus.ITRemain, 1); tick();
    idle(); settle(); chk("it_done_act", bus.ITActive, 1'b0); chk("it_done_rem", bus.ITRemain, 0);

    // IT len 2 with bubble and 2-cycle stall between slots
    it_start(4'hE, 2, 4'b1111); settle(); tick();
    instr(4'hE); settle(); tick();
    idle(); settle(); tick();
    for (int k = 0; k < 2; k++) begin
      instr(4'hE); bus.StallE = 1'b1; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'hF;
      settle(); tick();
    end
    idle(); settle();
    chk("stall_rem", bus.ITRemain, 1); chk("stall_flags", bus.FlagsOut, 4'b0100);
    instr(4'hE); settle(); tick();
    idle(); settle(); chk("stall_done", bus.ITActive, 1'b0);

    // Flush mid-block, bad length, nested IT, reset mid-block
    it_start(4'hE, 3, 4'b1111); settle(); tick();
    instr(4'hE); settle(); tick();
    instr(4'hE); bus.FlushE = 1'b1; settle(); chk("fl_rem", bus.ITRemain, 2); tick();
    idle(); settle(); chk("fl_act", bus.ITActive, 1'b0); chk("fl_rem0", bus.ITRemain, 0);
    it_start(4'hE, 0, 4'b1111); settle(); tick();
    idle(); settle(); chk("len0_err", bus.ITError, 1'b1); chk("len0_act", bus.ITActive, 1'b0); tick();
    settle(); chk("len0_pulse", bus.ITError, 1'b0);
    it_start(4'hE, 2, 4'b1111); settle(); tick();
    it_start(4'hE, 3, 4'b1111); settle(); tick();
    idle(); settle(); chk("nest_err", bus.ITError, 1'b1); chk("nest_rem", bus.ITRemain, 1);
    instr(4'hE); settle(); tick();
    idle(); settle(); chk("nest_done", bus.ITActive, 1'b0);
    it_start(4'hE, 3, 4'b1111); settle(); tick();
    idle(); RESET = 1'b1; settle(); tick();
    instr(4'h0); settle(); chk("rst_abort_act", bus.ITActive, 1'b0); chk("rst_abort_eq", bus.CondExE, 1'b0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      RESET            = ($urandom_range(0, 99) == 0);
      bus.ValidE       = ($urandom_range(0, 99) < 80);
      bus.StallE       = ($urandom_range(0, 99) < 15);
      bus.FlushE       = ($urandom_range(0, 99) < 5);
      bus.PCSrcEIn     = 1'($urandom);
      bus.RegWriteEIn  = 1'($urandom);
      bus.MemWriteEIn  = 1'($urandom);
      bus.BranchEIn    = 1'($urandom);
      bus.NoWrite      = 1'($urandom);
      bus.FlagWriteE   = 2'($urandom);
      bus.CondE        = 4'($urandom);
      bus.ALUFlags     = 4'($urandom);
      bus.ITStartE     = ($urandom_range(0, 99) < 15);
      bus.ITCondE      = 4'($urandom_range(0, 14));
      bus.ITLenE       = CNT_W'($urandom);
      bus.ITMaskE      = IT_DEPTH'($urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
